stack_row_datapath: RTL and testbench
=====================================

Name: stack_row_datapath

Overview:
Parametrised successor to the fixed-width gameplay datapath. Owns a bouncing block, its width, row height, speed, score and chances.
- On a player drop it computes the overlap with the previous row and trims the block to that overlap.
- It then advances the row and speeds up, or charges a chance on a miss.
- It feeds the display path and replaces the external FSM with an internal one.

Parameters:
X_W, 8, width of x coordinates and block width
Y_W, 7, width of y coordinate
SCREEN_W, 160, playfield width in pixels (legal x is 0..SCREEN_W-1)
Y_BOTTOM, 116, y of the base row
ROW_H, 4, pixel height of one row
INIT_W, 40, starting block width (1..SCREEN_W-1)
CHANCES, 10, misses allowed before game over
SCORE_W, 8, score width
SPEED_BASE, 2000000, clk cycles per 1-pixel move at level 0
SPEED_STEP, 100000, period decrement per placement
SPEED_MIN, 200000, period floor

Ports:
clk  in  1  50MHz system clock
resetn  in  1  asynchronous active-low reset
start  in  1  pulse: begin/restart game
drop  in  1  pulse: player drops moving block
cur_x  out  X_W  moving block left edge
cur_w  out  X_W  moving block width
cur_y  out  Y_W  moving block row y
prev_x  out  X_W  placed row left edge
prev_w  out  X_W  placed row width
score  out  SCORE_W  rows placed
chances  out  4  chances left
moving  out  1  state==MOVE (drop accepted)
placed  out  1  1-cycle pulse on successful placement
missed  out  1  1-cycle pulse on miss
game_over  out  1  level, set in OVER
win  out  1  level, game ended by reaching top
perfect  out  1  1-cycle pulse, snap feature only (0 when compiled out)

Behaviour:
- Reset (async, resetn=0) values:
  - state=IDLE, cur_x=0, cur_w=INIT_W, cur_y=Y_BOTTOM-ROW_H.
  - prev_x=(SCREEN_W-INIT_W)/2, prev_w=INIT_W.
  - score=0, chances=CHANCES, period=SPEED_BASE, tick counter=0, dir=right.
  - All pulses, game_over and win are 0.
- States:
  - IDLE: on start, go to MOVE.
  - MOVE: the block bounces; on drop, go to EVAL.
  - EVAL: one cycle, overlap computed and latched; go to UPDATE.
  - UPDATE: apply result, assert a pulse; go to MOVE or OVER.
  - OVER: hold all outputs; on start, go to MOVE with reset-equivalent game values.
- start in any state takes priority over drop and reinitialises the game values.
- Movement happens only in MOVE. The tick counter counts 0..period-1; on the wrap cycle:
  - dir right and cur_x+cur_w>=SCREEN_W: dir<=left, cur_x<=cur_x-1.
  - dir left and cur_x==0: dir<=right, cur_x<=cur_x+1.
  - otherwise cur_x steps by 1 in dir.
  - The tick counter clears on entry to MOVE.
- drop outside MOVE is ignored. Drop-to-pulse latency is exactly 2 cycles (drop sampled at edge N, pulse high after edge N+2).
- Overlap (in EVAL):
  - lo=max(cur_x,prev_x), hi=min(cur_x+cur_w, prev_x+prev_w).
  - Sums are computed at X_W+1 bits.
  - ov=hi-lo if hi>lo, else 0.
- UPDATE with ov>0:
  - prev_x<=lo, prev_w<=ov, cur_w<=ov, score<=score+1 (saturates at all ones).
  - period<=max(period-SPEED_STEP, SPEED_MIN).
  - cur_y<=cur_y-ROW_H, cur_x<=0, dir<=right, placed=1.
  - If the old cur_y<ROW_H (no row above): win<=1, game_over<=1, state OVER.
- UPDATE with ov==0:
  - missed=1, chances<=chances-1 (floor 0), cur_x<=0, dir<=right; y, width and prev are unchanged.
  - If the new chances==0: game_over<=1, state OVER, win=0.
- Width never grows. ov>=1 keeps cur_w>=1.
- Reset asserted mid-EVAL/UPDATE discards the result; no pulse is emitted.

Optional Feature:
STACK_PERFECT_SNAP_EN:
- When defined, localparam SNAP_TOL=2 applies.
- In EVAL, if |cur_x-prev_x|<=SNAP_TOL and cur_w==prev_w, the result is treated as ov=prev_w with lo=prev_x (no trim).
- perfect pulses alongside placed, and score increments by 2 (saturating).
- When undefined, there is no snap and perfect is tied to 0.

Test Plan:
- Reset then start with SPEED_BASE=4, SPEED_STEP=1, SPEED_MIN=2 -> cur_x increments every 4 cycles from 0; bounces at cur_x=120 (120+40=160) to 119.
- Drop at cur_x=70, prev_x=60, w=40 -> placed 2 cycles later; prev_x=70, prev_w=30, cur_w=30, cur_y=108, score=1, period=3.
- Drop at cur_x=0 with prev_x=60, prev_w=40 (no overlap) -> missed; chances 10->9, cur_y and cur_w unchanged.
- 10 consecutive misses -> chances=0, game_over=1, win=0; further drop is ignored; start -> score=0, chances=10, state MOVE.
- Y_BOTTOM=8, ROW_H=4: two overlapping drops -> second asserts placed, win=1 and game_over=1.
- Drop and start in the same cycle -> no pulse; game reinitialised. With STACK_PERFECT_SNAP_EN, a drop at prev_x+1 -> perfect=1, width kept 40, score+=2.

Source files
------------

// File: rtl/stack_row_datapath.sv
// Stacker gameplay datapath: bouncing block, overlap trim, row/speed/score/chance bookkeeping.
// Drop-to-pulse latency 2 cycles; start overrides everything. Optional STACK_PERFECT_SNAP_EN snaps near-perfect drops.
module stack_row_datapath #(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int SCREEN_W   = 160,
    parameter int Y_BOTTOM   = 116,
    parameter int ROW_H      = 4,
    parameter int INIT_W     = 40,
    parameter int CHANCES    = 10,
    parameter int SCORE_W    = 8,
    parameter int SPEED_BASE = 2000000,
    parameter int SPEED_STEP = 100000,
    parameter int SPEED_MIN  = 200000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               drop,
    output logic [X_W-1:0]     cur_x,
    output logic [X_W-1:0]     cur_w,
    output logic [Y_W-1:0]     cur_y,
    output logic [X_W-1:0]     prev_x,
    output logic [X_W-1:0]     prev_w,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         chances,
    output logic               moving,
    output logic               placed,
    output logic               missed,
    output logic               game_over,
    output logic               win,
    output logic               perfect
);
    localparam int P_W = $clog2(SPEED_BASE + 1);

    localparam logic [X_W-1:0] INIT_W_X  = X_W'(INIT_W);
    localparam logic [X_W-1:0] PREV_X0   = X_W'((SCREEN_W - INIT_W) / 2);
    localparam logic [X_W:0]   SCREEN_X  = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W-1:0] ROW_H_Y   = Y_W'(ROW_H);
    localparam logic [Y_W-1:0] Y0        = Y_W'(Y_BOTTOM - ROW_H);
    localparam logic [3:0]     CH0       = 4'(CHANCES);
    localparam logic [P_W-1:0] P_BASE    = P_W'(SPEED_BASE);
    localparam logic [P_W-1:0] P_STEP    = P_W'(SPEED_STEP);
    localparam logic [P_W-1:0] P_MIN     = P_W'(SPEED_MIN);
    localparam logic [P_W:0]   P_THRESH  = (P_W+1)'(SPEED_MIN + SPEED_STEP);

    typedef enum logic [2:0] {S_IDLE, S_MOVE, S_EVAL, S_UPDATE, S_OVER} state_t;
    state_t state, state_nxt;

    logic               dir_left;
    logic [P_W-1:0]     period, tick;
    logic [X_W-1:0]     lo_q, ov_q, lo_c, ov_c;
    logic               snap_q, snap_c;
    logic [X_W:0]       cur_end, prev_end, hi_c;
    logic               tick_wrap;
    logic [3:0]         chances_dec;
    logic [SCORE_W:0]   score_inc;
    logic [SCORE_W-1:0] score_sat;
    logic [P_W-1:0]     period_dec;

    assign moving      = (state == S_MOVE);
    assign tick_wrap   = (tick == period - P_W'(1));
    assign chances_dec = (chances == 4'd0) ? 4'd0 : chances - 4'd1;
    assign score_inc   = {1'b0, score} + {{(SCORE_W-1){1'b0}}, snap_q, ~snap_q};
    assign score_sat   = score_inc[SCORE_W] ? '1 : score_inc[SCORE_W-1:0];
    assign period_dec  = ({1'b0, period} >= P_THRESH) ? period - P_STEP : P_MIN;

`ifdef STACK_PERFECT_SNAP_EN
    localparam logic [X_W-1:0] SNAP_TOL = X_W'(2);
    logic [X_W-1:0] dist;
    assign dist = (cur_x >= prev_x) ? cur_x - prev_x : prev_x - cur_x;
`endif

    // Sums carry one extra bit so a block touching the right edge cannot wrap.
    always_comb begin
        cur_end  = {1'b0, cur_x} + {1'b0, cur_w};
        prev_end = {1'b0, prev_x} + {1'b0, prev_w};
        lo_c     = (cur_x > prev_x) ? cur_x : prev_x;
        hi_c     = (cur_end < prev_end) ? cur_end : prev_end;
        ov_c     = (hi_c > {1'b0, lo_c}) ? X_W'(hi_c - {1'b0, lo_c}) : '0;
        snap_c   = 1'b0;
`ifdef STACK_PERFECT_SNAP_EN
        if (dist <= SNAP_TOL && cur_w == prev_w) begin
            lo_c   = prev_x;
            ov_c   = prev_w;
            snap_c = 1'b1;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_MOVE;
        end else begin
            case (state)
                S_MOVE:   if (drop) state_nxt = S_EVAL;
                S_EVAL:   state_nxt = S_UPDATE;
                S_UPDATE: begin
                    if (ov_q != '0) state_nxt = (cur_y < ROW_H_Y) ? S_OVER : S_MOVE;
                    else            state_nxt = (chances_dec == 4'd0) ? S_OVER : S_MOVE;
                end
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_x <= '0;  cur_w <= INIT_W_X;  cur_y <= Y0;
            prev_x <= PREV_X0;  prev_w <= INIT_W_X;
            score <= '0;  chances <= CH0;  period <= P_BASE;  tick <= '0;
            dir_left <= 1'b0;  game_over <= 1'b0;  win <= 1'b0;
            placed <= 1'b0;  missed <= 1'b0;
            lo_q <= '0;  ov_q <= '0;  snap_q <= 1'b0;
`ifdef STACK_PERFECT_SNAP_EN
            perfect <= 1'b0;
`endif
        end else begin
            placed <= 1'b0;
            missed <= 1'b0;
`ifdef STACK_PERFECT_SNAP_EN
            perfect <= 1'b0;
`endif
            if (start) begin
                cur_x <= '0;  cur_w <= INIT_W_X;  cur_y <= Y0;
                prev_x <= PREV_X0;  prev_w <= INIT_W_X;
                score <= '0;  chances <= CH0;  period <= P_BASE;  tick <= '0;
                dir_left <= 1'b0;  game_over <= 1'b0;  win <= 1'b0;
            end else begin
                case (state)
                    S_MOVE: if (!drop) begin
                        if (tick_wrap) begin
                            tick <= '0;
                            if (!dir_left && ({1'b0, cur_x} + {1'b0, cur_w} >= SCREEN_X)) begin
                                dir_left <= 1'b1;
                                cur_x    <= cur_x - X_W'(1);
                            end else if (dir_left && cur_x == '0) begin
                                dir_left <= 1'b0;
                                cur_x    <= cur_x + X_W'(1);
                            end else begin
                                cur_x <= dir_left ? cur_x - X_W'(1) : cur_x + X_W'(1);
                            end
                        end else begin
                            tick <= tick + P_W'(1);
                        end
                    end
                    S_EVAL: begin
                        lo_q   <= lo_c;
                        ov_q   <= ov_c;
                        snap_q <= snap_c;
                    end
                    S_UPDATE: begin
                        cur_x    <= '0;
                        dir_left <= 1'b0;
                        tick     <= '0;
                        if (ov_q != '0) begin
                            prev_x <= lo_q;
                            prev_w <= ov_q;
                            cur_w  <= ov_q;
                            score  <= score_sat;
                            period <= period_dec;
                            cur_y  <= cur_y - ROW_H_Y;
                            placed <= 1'b1;
`ifdef STACK_PERFECT_SNAP_EN
                            perfect <= snap_q;
`endif
                            if (cur_y < ROW_H_Y) begin
                                win       <= 1'b1;
                                game_over <= 1'b1;
                            end
                        end else begin
                            missed  <= 1'b1;
                            chances <= chances_dec;
                            if (chances_dec == 4'd0) game_over <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifndef STACK_PERFECT_SNAP_EN
    assign perfect = 1'b0;
`endif
endmodule

// File: tb/tb_stack_row_datapath.sv
// Bench for stack_row_datapath: hand tables, corner sequences, and a randomized game-level model.
module tb_stack_row_datapath;
    localparam int SCREEN_W = 160;
    localparam int T_BASE = 4, T_STEP = 1, T_MIN = 2;

    logic clk = 1'b0, resetn = 1'b0, start = 1'b0, drop = 1'b0;
    logic [7:0] cur_x, cur_w, prev_x, prev_w, score;
    logic [6:0] cur_y;
    logic [3:0] chances;
    logic moving, placed, missed, game_over, win, perfect;

    logic start2 = 1'b0, drop2 = 1'b0;
    logic [7:0] cur_x2, cur_w2, prev_x2, prev_w2, score2;
    logic [6:0] cur_y2;
    logic [3:0] chances2;
    logic moving2, placed2, missed2, game_over2, win2, perfect2;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    stack_row_datapath #(.SPEED_BASE(T_BASE), .SPEED_STEP(T_STEP), .SPEED_MIN(T_MIN)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .drop(drop),
        .cur_x(cur_x), .cur_w(cur_w), .cur_y(cur_y), .prev_x(prev_x), .prev_w(prev_w),
        .score(score), .chances(chances), .moving(moving), .placed(placed), .missed(missed),
        .game_over(game_over), .win(win), .perfect(perfect));

    stack_row_datapath #(.Y_BOTTOM(8), .SPEED_BASE(T_BASE), .SPEED_STEP(T_STEP), .SPEED_MIN(T_MIN)) u_dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .drop(drop2),
        .cur_x(cur_x2), .cur_w(cur_w2), .cur_y(cur_y2), .prev_x(prev_x2), .prev_w(prev_w2),
        .score(score2), .chances(chances2), .moving(moving2), .placed(placed2), .missed(missed2),
        .game_over(game_over2), .win(win2), .perfect(perfect2));

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Wait n MOVE cycles after entry, then drop; returns just after the drop edge.
    task automatic do_drop(input int n);
        repeat (n) step();
        drop = 1'b1;
        step();
        drop = 1'b0;
    endtask

    // Block position after k moves from x=0 heading right: triangle wave over 0..SCREEN_W-w.
    function automatic int tri_pos(input int k, input int w);
        int span, p;
        span = SCREEN_W - w;
        p = k % (2 * span);
        return (p <= span) ? p : 2 * span - p;
    endfunction

    // Game-level reference model
    int m_prev_x, m_prev_w, m_cur_w, m_score, m_chances, m_period, m_over, m_win;
    int m_placed, m_missed, m_perfect;
    logic [6:0] m_cur_y;

    task automatic m_init();
        m_prev_x = 60; m_prev_w = 40; m_cur_w = 40; m_cur_y = 7'd112;
        m_score = 0; m_chances = 10; m_period = T_BASE; m_over = 0; m_win = 0;
    endtask

    task automatic m_drop(input int x);
        int lo, hi, ov, snap;
        lo = (x > m_prev_x) ? x : m_prev_x;
        hi = (x + m_cur_w < m_prev_x + m_prev_w) ? x + m_cur_w : m_prev_x + m_prev_w;
        ov = (hi > lo) ? hi - lo : 0;
        snap = 0;
`ifdef STACK_PERFECT_SNAP_EN
        if ((x - m_prev_x <= 2) && (m_prev_x - x <= 2) && m_cur_w == m_prev_w) begin
            lo = m_prev_x; ov = m_prev_w; snap = 1;
        end
`endif
        m_placed = 0; m_missed = 0; m_perfect = 0;
        if (ov > 0) begin
            m_placed = 1; m_perfect = snap;
            m_prev_x = lo; m_prev_w = ov; m_cur_w = ov;
            m_score = m_score + (snap ? 2 : 1);
            if (m_score > 255) m_score = 255;
            m_period = (m_period - T_STEP > T_MIN) ? m_period - T_STEP : T_MIN;
            if (m_cur_y < 7'd4) begin m_win = 1; m_over = 1; end
            m_cur_y = m_cur_y - 7'd4;
        end else begin
            m_missed = 1;
            if (m_chances > 0) m_chances--;
            if (m_chances == 0) m_over = 1;
        end
    endtask

    typedef struct {
        int wait_n; int x; int placed; int prev_x; int prev_w;
        int cur_w; int cur_y; int score; int chances;
    } vec_t;
    vec_t tbl[4];

    initial begin
        tbl[0] = '{280, 70, 1, 70, 30, 30, 108, 1, 10};
        tbl[1] = '{0, 0, 0, 70, 30, 30, 108, 1, 9};
        tbl[2] = '{225, 75, 1, 75, 25, 25, 104, 2, 9};
        tbl[3] = '{280, 130, 0, 75, 25, 25, 104, 2, 8};

        #12;
        chk("rst cur_x", cur_x, 0);     chk("rst cur_w", cur_w, 40);
        chk("rst cur_y", cur_y, 112);   chk("rst prev_x", prev_x, 60);
        chk("rst prev_w", prev_w, 40);  chk("rst score", score, 0);
        chk("rst chances", chances, 10); chk("rst moving", moving, 0);
        chk("rst pulses", {placed, missed, perfect}, 0);
        chk("rst over", {game_over, win}, 0);
        resetn = 1'b1;
        step();

        // Movement cadence and right-edge bounce
        do_start();
        chk("move entered", moving, 1);
        repeat (3) step();  chk("x hold k3", cur_x, 0);
        step();             chk("x step k4", cur_x, 1);
        repeat (476) step(); chk("x at edge", cur_x, 120);
        repeat (4) step();  chk("x bounced", cur_x, 119);

        // Table: consecutive drops from a fresh game
        do_start();
        for (int i = 0; i < 4; i++) begin
            do_drop(tbl[i].wait_n);
            chk($sformatf("t%0d x", i), cur_x, tbl[i].x);
            step();
            chk($sformatf("t%0d early pulse", i), {placed, missed}, 0);
            step();
            chk($sformatf("t%0d placed", i), placed, tbl[i].placed);
            chk($sformatf("t%0d missed", i), missed, 1 - tbl[i].placed);
            chk($sformatf("t%0d prev_x", i), prev_x, tbl[i].prev_x);
            chk($sformatf("t%0d prev_w", i), prev_w, tbl[i].prev_w);
            chk($sformatf("t%0d cur_w", i), cur_w, tbl[i].cur_w);
            chk($sformatf("t%0d cur_y", i), cur_y, tbl[i].cur_y);
            chk($sformatf("t%0d score", i), score, tbl[i].score);
            chk($sformatf("t%0d chances", i), chances, tbl[i].chances);
        end

        // Ten misses end the game; drops are then ignored; start restarts
        do_start();
        for (int i = 0; i < 10; i++) begin
            do_drop(0);
            step(); step();
            chk($sformatf("miss%0d pulse", i), missed, 1);
            chk($sformatf("miss%0d chances", i), chances, 9 - i);
            step();
            chk($sformatf("miss%0d pulse low", i), missed, 0);
        end
        chk("miss over", game_over, 1);
        chk("miss no win", win, 0);
        chk("miss not moving", moving, 0);
        drop = 1'b1; step(); drop = 1'b0; step(); step();
        chk("over drop ignored", {placed, missed}, 0);
        chk("over chances held", chances, 0);
        do_start();
        chk("restart score", score, 0);
        chk("restart chances", chances, 10);
        chk("restart moving", moving, 1);
        chk("restart over", game_over, 0);

        // Drop colliding with start: no pulse, game reinitialised
        do_drop(280);
        step(); step();
        chk("pre-collide score", score, 1);
        drop = 1'b1; start = 1'b1; step(); drop = 1'b0; start = 1'b0;
        chk("collide pulse c0", {placed, missed}, 0);
        step(); chk("collide pulse c1", {placed, missed}, 0);
        step(); chk("collide pulse c2", {placed, missed}, 0);
        chk("collide score", score, 0);
        chk("collide cur_w", cur_w, 40);
        chk("collide moving", moving, 1);

        // Near-perfect drop one pixel right of the base row
        do_start();
        do_drop(244);
        chk("snap x", cur_x, 61);
        step(); step();
        chk("snap placed", placed, 1);
`ifdef STACK_PERFECT_SNAP_EN
        chk("snap perfect", perfect, 1);
        chk("snap cur_w", cur_w, 40);
        chk("snap prev_x", prev_x, 60);
        chk("snap score", score, 2);
`else
        chk("nosnap perfect", perfect, 0);
        chk("nosnap cur_w", cur_w, 39);
        chk("nosnap prev_x", prev_x, 61);
        chk("nosnap score", score, 1);
`endif

        // Reset during EVAL discards the result
        do_drop(10);
        resetn = 1'b0;
        step(); chk("rst-eval pulse a", {placed, missed}, 0);
        step(); resetn = 1'b1;
        step(); chk("rst-eval pulse b", {placed, missed}, 0);
        chk("rst-eval moving", moving, 0);
        chk("rst-eval score", score, 0);
        chk("rst-eval cur_w", cur_w, 40);

        // Short playfield: second placement reaches the top
        start2 = 1'b1; step(); start2 = 1'b0;
        repeat (240) step(); drop2 = 1'b1; step(); drop2 = 1'b0;
        chk("top x1", cur_x2, 60);
        step(); step();
        chk("top placed1", placed2, 1);
        chk("top cur_y1", cur_y2, 0);
        chk("top win1", win2, 0);
        repeat (180) step(); drop2 = 1'b1; step(); drop2 = 1'b0;
        chk("top x2", cur_x2, 60);
        step(); step();
        chk("top placed2", placed2, 1);
        chk("top win2", win2, 1);
        chk("top over2", game_over2, 1);
        chk("top moving2", moving2, 0);

        // Randomized play against the game-level model
        do_start();
        m_init();
        for (int i = 0; i < 40; i++) begin
            int n, x;
            n = $urandom_range(0, 150);
            x = tri_pos(n / m_period, m_cur_w);
            do_drop(n);
            chk($sformatf("r%0d x", i), cur_x, x);
            m_drop(x);
            step(); step();
            chk($sformatf("r%0d placed", i), placed, m_placed);
            chk($sformatf("r%0d missed", i), missed, m_missed);
            chk($sformatf("r%0d perfect", i), perfect, m_perfect);
            chk($sformatf("r%0d prev_x", i), prev_x, m_prev_x);
            chk($sformatf("r%0d prev_w", i), prev_w, m_prev_w);
            chk($sformatf("r%0d cur_w", i), cur_w, m_cur_w);
            chk($sformatf("r%0d cur_y", i), cur_y, int'(m_cur_y));
            chk($sformatf("r%0d score", i), score, m_score);
            chk($sformatf("r%0d chances", i), chances, m_chances);
            chk($sformatf("r%0d over", i), {game_over, win}, {m_over[0], m_win[0]});
            if (m_over != 0) begin
                do_start();
                m_init();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
